// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size codes, the
// two-beat FSM state type and the natural-alignment rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } dmem_state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr[0] == 1'b0);
      SZ_WORD: ok = (addr[1:0] == 2'b00);
      default: ok = (addr == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage: 32-bit words with per-byte write enables, registered
// read port, power-up contents selected by INIT_PATTERN.
module dmem_bank #(
  parameter int unsigned ADDR_W       = 10,
  parameter bit          INIT_PATTERN = 1'b1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-3:0] widx_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned WI_W   = ADDR_W - 2;
  localparam int unsigned NWORDS = 2 ** WI_W;

  logic [31:0] words [NWORDS];
  logic [31:0] rdata_q;

  // Each word is its own register so its power-up value can be a constant;
  // byte 4w+3 (lane 3, bits 7:0) carries (4w+4) mod 256 when preloaded.
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    localparam logic [31:0] INIT = INIT_PATTERN ? {24'h0, 8'(4 * w + 4)} : 32'h0;
    logic [31:0] word_q = INIT;

    always_ff @(posedge clk_i) begin
      if (we_i && (widx_i == WI_W'(w))) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (be_i[k]) word_q[8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end

    assign words[w] = word_q;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= words[widx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_unit.sv
// Handshaked big-endian data memory for the MEM stage: byte/half/word in one
// beat, doubles in two beats over the 32-bit bank, misaligned requests faulted.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter bit          INIT_PATTERN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_misalign
);

  localparam int unsigned    WI_W      = ADDR_W - 2;
  localparam logic [WI_W-1:0] WIDX_STEP = WI_W'(1);

  dmem_state_t state_q, state_d;

  logic            accept, aligned;
  logic            rsp_valid_q, rsp_valid_d, rsp_mis_q;
  logic            wr_q;
  logic [WI_W-1:0] widx_q;
  logic [31:0]     whi_q, lo_q;
  logic [1:0]      rsz_q, roff_q;
  logic            rsgn_q, rzero_q;
  logic [63:0]     hold_q, fresh_rdata;

  logic            bk_we, bk_re;
  logic [3:0]      bk_be;
  logic [WI_W-1:0] bk_widx;
  logic [31:0]     bk_wdata, bk_rdata;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign aligned = is_aligned(req_size, req_addr[2:0]);

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    bk_we       = 1'b0;
    bk_re       = 1'b0;
    bk_be       = 4'b0000;
    bk_widx     = req_addr[ADDR_W-1:2];
    bk_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rsp_valid_d = (req_size != SZ_DOUBLE) || !aligned;
          if (aligned) begin
            bk_we = req_write;
            bk_re = !req_write;
            case (req_size)
              SZ_BYTE: begin
                bk_be    = 4'b1000 >> req_addr[1:0];
                bk_wdata = {4{req_wdata[7:0]}};
              end
              SZ_HALF: begin
                bk_be    = req_addr[1] ? 4'b0011 : 4'b1100;
                bk_wdata = {2{req_wdata[15:0]}};
              end
              default: begin
                bk_be    = 4'b1111;
                bk_wdata = req_wdata[31:0];
              end
            endcase
            if (req_size == SZ_DOUBLE) state_d = ST_BEAT2;
          end
        end
      end
      ST_BEAT2: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        bk_we       = wr_q;
        bk_re       = !wr_q;
        bk_be       = 4'b1111;
        bk_widx     = widx_q;
        bk_wdata    = whi_q;
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset landing on the second beat drops it; beat 0 has already committed.
    if (rst) begin
      bk_we = 1'b0;
      bk_re = 1'b0;
    end
  end

  dmem_bank #(
    .ADDR_W       (ADDR_W),
    .INIT_PATTERN (INIT_PATTERN)
  ) u_bank (
    .clk_i   (clk),
    .we_i    (bk_we),
    .re_i    (bk_re),
    .be_i    (bk_be),
    .widx_i  (bk_widx),
    .wdata_i (bk_wdata),
    .rdata_o (bk_rdata)
  );

  always_comb begin
    half_v = roff_q[1] ? bk_rdata[15:0] : bk_rdata[31:16];
    case (roff_q)
      2'd0:    byte_v = bk_rdata[31:24];
      2'd1:    byte_v = bk_rdata[23:16];
      2'd2:    byte_v = bk_rdata[15:8];
      default: byte_v = bk_rdata[7:0];
    endcase
    case (rsz_q)
      SZ_BYTE: fresh_rdata = {{56{rsgn_q & byte_v[7]}}, byte_v};
      SZ_HALF: fresh_rdata = {{48{rsgn_q & half_v[15]}}, half_v};
      SZ_WORD: fresh_rdata = {{32{rsgn_q & bk_rdata[31]}}, bk_rdata};
      default: fresh_rdata = {bk_rdata, lo_q};
    endcase
    if (rzero_q) fresh_rdata = '0;
  end

  // Read data is only meaningful in the response cycle; hold_q keeps the
  // last response visible while the bank read port moves on.
  assign rsp_rdata    = rsp_valid_q ? fresh_rdata : hold_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_misalign = rsp_mis_q;
  assign req_ready    = (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      hold_q      <= rsp_rdata;
      if (rsp_valid_d) rsp_mis_q <= (state_q == ST_IDLE) && !aligned;
      if (accept) begin
        wr_q    <= req_write;
        widx_q  <= req_addr[ADDR_W-1:2] + WIDX_STEP;
        whi_q   <= req_wdata[63:32];
        rsz_q   <= req_size;
        roff_q  <= req_addr[1:0];
        rsgn_q  <= req_signed;
        rzero_q <= req_write || !aligned;
      end
      if (state_q == ST_BEAT2) lo_q <= bk_rdata;
    end
    if (!rst && state_q == ST_BEAT2) assert (widx_q != '0);
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Randomised self-checking bench for dmem_unit against a byte-array model.
module tb_dmem_unit;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_misalign;

  dmem_unit #(
    .ADDR_W       (ADDR_W),
    .INIT_PATTERN (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_misalign (rsp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  mdl [MEM_BYTES];
  logic [63:0] last_d;
  logic        last_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd3) ? 8 : (1 << sz);
  endfunction

  function automatic logic [63:0] rd_be(input int unsigned a, input int unsigned n);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = (v << 8) | 64'(mdl[(a + i) % MEM_BYTES]);
    return v;
  endfunction

  task automatic wr_be(input int unsigned a, input int unsigned n, input logic [63:0] val);
    for (int unsigned i = 0; i < n; i++) mdl[(a + i) % MEM_BYTES] = 8'(val >> (8 * (n - 1 - i)));
  endtask

  function automatic logic [63:0] mdl_load(input logic [1:0] sz, input logic sg, input int unsigned a);
    int unsigned n;
    logic [63:0] v, hi;
    n = nbytes(sz);
    if (n == 8) begin
      hi = rd_be(a + 4, 4);
      v  = rd_be(a, 4);
      return (hi << 32) | v;
    end
    v = rd_be(a, n);
    if (sg && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input int unsigned a, input logic [63:0] wd);
    if (sz == 2'd3) begin
      wr_be(a, 4, wd);
      wr_be(a + 4, 4, wd >> 32);
    end else begin
      wr_be(a, nbytes(sz), wd);
    end
  endtask

  // Starts at a negedge with the unit idle; returns at the negedge of the response cycle.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input int unsigned a, input logic [63:0] wd);
    logic [63:0] exp_d;
    logic        exp_m, dbl;
    exp_m = (a % nbytes(sz)) != 0;
    dbl   = (sz == 2'd3) && !exp_m;
    exp_d = '0;
    if (!exp_m) begin
      if (w) mdl_store(sz, a, wd);
      else   exp_d = mdl_load(sz, sg, a);
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ADDR_W'(a);
    req_wdata  = wd;
    chk("ready_at_req", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (dbl) begin
      chk("dbl_gap_valid", 64'(rsp_valid), 64'd0);
      chk("dbl_gap_ready", 64'(req_ready), 64'd0);
      chk("dbl_gap_hold",  rsp_rdata, last_d);
      chk("dbl_gap_mis",   64'(rsp_misalign), 64'(last_m));
      @(negedge clk);
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_rdata", rsp_rdata, exp_d);
    chk("rsp_mis",   64'(rsp_misalign), 64'(exp_m));
    chk("rsp_ready", 64'(req_ready), 64'd1);
    last_d = exp_d;
    last_m = exp_m;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    chk("idle_hold",  rsp_rdata, last_d);
    chk("idle_mis",   64'(rsp_misalign), 64'(last_m));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w, sg;
    logic [1:0]  sz;
    int unsigned a;
    logic [63:0] wd;

    for (int unsigned i = 0; i < MEM_BYTES; i++)
      mdl[i] = (((i + 1) % 4) == 0) ? 8'(i + 1) : 8'h00;
    last_d     = '0;
    last_m     = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_mis",   64'(rsp_misalign), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd1);

    issue(1'b0, 2'd2, 1'b0, 'h000, '0);
    chk("preload_word", last_d, 64'h0000_0000_0000_0004);
    issue(1'b0, 2'd3, 1'b0, 'h000, '0);
    chk("preload_dbl", last_d, 64'h0000_0008_0000_0004);

    issue(1'b1, 2'd3, 1'b0, 'h010, 64'h1122_3344_5566_7788);
    issue(1'b0, 2'd2, 1'b0, 'h010, '0);
    chk("dbl_lo_word", last_d, 64'h5566_7788);
    issue(1'b0, 2'd2, 1'b0, 'h014, '0);
    chk("dbl_hi_word", last_d, 64'h1122_3344);

    issue(1'b1, 2'd0, 1'b0, 'h021, 64'hABCD_0000_0000_1280);
    issue(1'b0, 2'd0, 1'b1, 'h021, '0);
    chk("byte_signed", last_d, 64'hFFFF_FFFF_FFFF_FF80);
    issue(1'b0, 2'd0, 1'b0, 'h021, '0);
    chk("byte_unsigned", last_d, 64'h80);
    issue(1'b0, 2'd2, 1'b0, 'h020, '0);

    issue(1'b1, 2'd2, 1'b0, 'h002, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, 2'd1, 1'b0, 'h013, '0);
    issue(1'b0, 2'd2, 1'b0, 'h000, '0);
    chk("mis_no_effect", last_d, 64'h4);
    idle_check();

    // store then load on consecutive edges
    mdl_store(2'd2, 'h040, 64'hDEAD_BEEF);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = ADDR_W'('h040); req_wdata = 64'hDEAD_BEEF;
    @(posedge clk);
    #1 req_write = 1'b0;
    @(negedge clk);
    chk("b2b_st_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_st_rdata", rsp_rdata, 64'd0);
    chk("b2b_ready",    64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ld_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_ld_rdata", rsp_rdata, mdl_load(2'd2, 1'b0, 'h040));
    last_d = 64'hDEAD_BEEF;
    last_m = 1'b0;

    // reset lands on the second beat of a double store
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
    req_addr = ADDR_W'('h080); req_wdata = 64'hCAFE_F00D_A5A5_5A5A;
    @(posedge clk);
    #1 begin req_valid = 1'b0; rst = 1'b1; end
    @(negedge clk);
    chk("rstdbl_busy", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstdbl_valid", 64'(rsp_valid), 64'd0);
    chk("rstdbl_ready", 64'(req_ready), 64'd1);
    chk("rstdbl_rdata", rsp_rdata, 64'd0);
    wr_be('h080, 4, 64'hA5A5_5A5A);
    last_d = '0;
    last_m = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 'h080, '0);
    chk("rstdbl_lo", last_d, 64'hA5A5_5A5A);
    issue(1'b0, 2'd2, 1'b0, 'h084, '0);
    chk("rstdbl_hi", last_d, 64'h88);

    for (int unsigned t = 0; t < 400; t++) begin
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 0) ? $urandom_range(512, 575) : $urandom_range(0, MEM_BYTES - 1);
      if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
      wd = {$urandom, $urandom};
      issue(w, sz, sg, a, wd);
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Parametrised, handshaked data memory for the MEM stage. Replaces the fixed 1 KiB, always-combinational-write data memory with a synchronous single-port unit. It is byte-addressable and big-endian, and supports byte, half, word and double accesses with optional sign extension. It detects misalignment and runs a two-beat state machine for 64-bit accesses over a 32-bit-wide array. It sits between the EXE/MEM pipeline register and the MEM/WB register; the pipeline stalls while `req_ready` is low.

## Interface
- `ADDR_W`, 10: byte-address width; capacity 2^ADDR_W bytes (multiple of 8).
- `INIT_PATTERN`, 1: when 1, preload byte i with (i+1) mod 256 where (i+1)%4==0 and 0 elsewhere; when 0, preload all zero.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit accepts a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 double.
- `req_signed`  in  1  sign-extend load result (byte/half/word); ignored for double and stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  64  store data, right-justified.
- `rsp_valid`  out  1  one-cycle pulse: load data or store acknowledge.
- `rsp_rdata`  out  64  load result, right-justified; 0 for stores and faults.
- `rsp_misalign`  out  1  qualifies `rsp_valid`: access faulted, no memory effect.

## Operation
- Storage: 2^(ADDR_W-2) words × 32 bits with 4 byte enables. Byte at address a lives in word a>>2, lane a[1:0]. Lane 0 holds bits 31:24 (big-endian).
- Alignment: half requires a[0]=0; word requires a[1:0]=0; double requires a[2:0]=0. A misaligned request is accepted, performs no read or write, and returns rsp_valid=1, rsp_misalign=1, rsp_rdata=0.
- Byte/half/word: one beat. Stores write only the addressed lanes from the low bits of req_wdata. Loads zero-extend, or sign-extend when req_signed=1.
- Double layout: word at a holds bits 31:0; word at a+4 holds bits 63:32.
- FSM: IDLE, BEAT2.
  - IDLE to BEAT2 on accepting an aligned double; beat 0 (word a) executes on the accept edge and the request fields are latched.
  - BEAT2 to IDLE unconditionally; beat 1 (word a+4) executes on that edge.
- req_ready = (state==IDLE).
- Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_misalign=0; memory contents are not cleared.
- Reset during BEAT2: beat 0 store already committed, beat 1 dropped, no response.
- Address wrap: a+4 is computed modulo 2^ADDR_W. It cannot wrap for aligned doubles; this is asserted in simulation.

## Timing
- Accept at edge N (req_valid && req_ready).
- Single-beat access: rsp_valid high in cycle N+1.
- Double: req_ready low in cycle N+1; rsp_valid high in cycle N+2.
- Misaligned access: response in N+1, any size.
- Store-to-load: a store accepted at N is visible to a load accepted at N+1 (write-first on the edge). A load never sees stale data.
- Back-to-back single-beat requests sustain one per cycle; rsp_valid may stay high on consecutive cycles.
- rsp_rdata and rsp_misalign hold their values until the next response; consumers qualify them with rsp_valid.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_DOUBLE`;
  - FSM state type `dmem_state_t`;
  - function `is_aligned(size, addr[2:0])`.
- Sub-module `dmem_bank`: word array with 4 byte enables, synchronous write, read data available the cycle after address, preload per INIT_PATTERN.
- Top `dmem_unit` holds the FSM, lane steering, extension and response register.

## Test plan
- Preload check (INIT_PATTERN=1): load word 0x000 → 0x0000_0000_0000_0004; load double 0x000 → 0x0000_0008_0000_0004, with req_ready low for exactly one cycle.
- Double store then word loads: store double 0x1122334455667788 at 0x010 → ack at N+2; load word 0x010 → 0x55667788; load word 0x014 → 0x11223344.
- Byte signedness: store byte 0x80 at 0x021; signed byte load → 0xFFFF_FFFF_FFFF_FF80; unsigned → 0x80; word load 0x020 → 0x0080_0000 (with INIT_PATTERN=0).
- Misalignment: store word at 0x002 and load half at 0x013 → each rsp_misalign=1, rsp_rdata=0; a subsequent word load at 0x000 returns the unchanged value.
- Back-to-back: store word 0xDEADBEEF at 0x040 at N, load word 0x040 at N+1 → rsp_valid at N+1 and N+2, second response 0xDEADBEEF.
- Reset mid-double: assert rst in BEAT2 of a double store at 0x080 → no rsp_valid; word 0x080 holds the low half; word 0x084 is unchanged; req_ready=1 in the cycle after reset.
